ifid_skid_reg: RTL and testbench
================================

IFID_SKID_REG -- requirements
Module: ifid_skid_reg

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction word driven when no valid instruction is held.
REQ-002 SHALL have port i_clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_valid, input, 1, fetch stage presents a valid instruction.
REQ-005 SHALL have port i_pc, input, 32, fetch address of the presented instruction.
REQ-006 SHALL have port i_instr, input, 32, presented instruction word.
REQ-007 SHALL have port o_ready, output, 1, block accepts the upstream instruction this cycle.
REQ-008 SHALL have port i_ready, input, 1, decode stage consumes the output this cycle.
REQ-009 SHALL have port i_flush, input, 1, taken branch/jump; discard all held and arriving instructions.
REQ-010 SHALL have port o_valid, output, 1, output instruction valid.
REQ-011 SHALL have port o_pc, output, 32, PC of the output instruction.
REQ-012 SHALL have port o_pc_plus4, output, 32, o_pc + 4.
REQ-013 SHALL have port o_instr, output, 32, output instruction word.
REQ-014 SHALL have port o_stall_cnt, output, 16, count of cycles with o_valid=1 and i_ready=0.

Function
REQ-015 SHALL hold two registered entries, MAIN (drives outputs) and SKID, each with valid, pc and instr fields.
REQ-016 SHALL implement states EMPTY (no entry valid), ONE (MAIN only), FULL (MAIN and SKID).
REQ-017 SHALL drive o_ready = 1 in EMPTY and ONE and 0 in FULL; o_ready SHALL come from a register, not from i_ready.
REQ-018 SHALL accept upstream when i_valid & o_ready and consume downstream when o_valid & i_ready.
REQ-019 EMPTY: accept -> ONE, with data in MAIN and visible on outputs next cycle (1-cycle latency).
REQ-020 ONE: accept with no consume -> FULL (data into SKID); accept with consume -> ONE (new data into MAIN); consume only -> EMPTY; neither -> hold.
REQ-021 FULL: consume -> ONE, with SKID moved into MAIN; no consume -> hold all; no accept is possible in FULL.
REQ-022 SHALL preserve program order; no instruction is duplicated or dropped except by flush.
REQ-023 i_flush SHALL take priority over every other event: next state EMPTY, both valids cleared, any same-cycle upstream instruction discarded, o_ready=1 next cycle.
REQ-024 When o_valid=0, o_instr SHALL equal NOP_INSTR and o_pc SHALL hold its last value.
REQ-025 o_pc_plus4 SHALL be o_pc + 4 modulo 2^32 (wraps at 32'hFFFF_FFFC to 0).
REQ-026 o_stall_cnt SHALL increment by 1 each cycle o_valid=1 and i_ready=0, and saturate at 16'hFFFF; flush SHALL NOT clear it.
REQ-027 When i_valid=0, i_pc and i_instr SHALL be ignored.

Reset
REQ-028 Assertion of i_reset_n=0 SHALL immediately, independent of i_clk, force state EMPTY, o_valid=0, o_ready=1, o_pc=0, o_pc_plus4=4, o_instr=NOP_INSTR and o_stall_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard both entries without emitting them; the first accept after deassertion SHALL follow REQ-019.

Structure
REQ-030 The state enum (EMPTY/ONE/FULL) and the NOP constant SHALL live in the shared core package; the entry struct {valid, pc, instr} SHALL also be declared there.
REQ-031 SHALL be a single flat module with no sub-modules; the saturating counter remains inline.

Verification
REQ-032 Reset: drive i_reset_n=0 mid-cycle -> outputs take reset values of REQ-028 before the next edge.
REQ-033 Streaming: i_ready=1, PCs 0x0,0x4,0x8 with distinct instrs on consecutive cycles -> same sequence on o_pc/o_instr one cycle later, o_ready constantly 1.
REQ-034 Backpressure: hold i_ready=0 while feeding 0x10,0x14 -> FULL, o_ready=0, o_pc=0x10; release i_ready -> 0x10 then 0x14 emitted in order, o_stall_cnt equals the stalled cycles.
REQ-035 Flush in FULL with i_valid=1 (pc 0x18) -> next cycle o_valid=0, o_instr=32'h0000_0013, o_ready=1; 0x10, 0x14 and 0x18 never appear.
REQ-036 Wrap: accept pc 32'hFFFF_FFFC -> o_pc_plus4=0.
REQ-037 Saturation: preload stall condition for 65540 cycles -> o_stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/ifid_skid_reg_pkg.sv
// Shared types for the IF/ID skid register: occupancy states, the entry record
// and the bubble instruction (addi x0,x0,0).
package ifid_skid_reg_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } ifid_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_skid_reg_if.sv
// Valid/ready instruction bus between pipeline stages; the master presents
// pc/instr, the slave returns ready.
interface ifid_skid_reg_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] instr;

  modport master (output valid, output pc, output instr, input  ready);
  modport slave  (input  valid, input  pc, input  instr, output ready);
endinterface

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer so o_ready is registered
// and never depends combinationally on the decode stage's i_ready.
module ifid_skid_reg
  import ifid_skid_reg_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_ready,
  input  logic        i_ready,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instr,
  output logic [15:0] o_stall_cnt
);

  ifid_state_e state_q, state_d;
  ifid_entry_t main_q, main_d;
  ifid_entry_t skid_q, skid_d;
  logic        ready_q, ready_d;
  logic [15:0] stall_q, stall_d;

  logic        accept, consume;
  ifid_entry_t in_entry;

  assign accept   = i_valid & ready_q;
  assign consume  = main_q.valid & i_ready;
  assign in_entry = '{valid: 1'b1, pc: i_pc, instr: i_instr};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // pc fields are kept so o_pc holds its last value while idle
      state_d      = ST_EMPTY;
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !consume) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (accept && consume) begin
            main_d  = in_entry;
          end else if (consume) begin
            main_d.valid = 1'b0;
            state_d      = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_d       = skid_q;
            skid_d.valid = 1'b0;
            state_d      = ST_ONE;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_d.valid = 1'b0;
          skid_d.valid = 1'b0;
        end
      endcase
    end
    ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    stall_d = stall_q;
    if (main_q.valid && !i_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR};
      skid_q  <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR};
      ready_q <= 1'b1;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      stall_q <= stall_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = main_q.valid;
  assign o_pc        = main_q.pc;
  assign o_pc_plus4  = main_q.pc + 32'd4;
  assign o_instr     = main_q.valid ? main_q.instr : NOP_INSTR;
  assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed vector table, async-reset and saturation
// sequences, and random traffic against a two-deep FIFO reference model.
module tb_ifid_skid_reg;
  import ifid_skid_reg_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_flush;
  logic [15:0] o_stall_cnt;
  logic [31:0] o_pc_plus4;

  ifid_skid_reg_if up ();
  ifid_skid_reg_if dn ();

  always #5 i_clk = ~i_clk;

  ifid_skid_reg #(.NOP_INSTR(NOP)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_valid    (up.valid),
    .i_pc       (up.pc),
    .i_instr    (up.instr),
    .o_ready    (up.ready),
    .i_ready    (dn.ready),
    .i_flush    (i_flush),
    .o_valid    (dn.valid),
    .o_pc       (dn.pc),
    .o_pc_plus4 (o_pc_plus4),
    .o_instr    (dn.instr),
    .o_stall_cnt(o_stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two instructions
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } mentry_t;
  mentry_t     mq[$];
  logic [31:0] m_last_pc;
  int          m_stall;

  task automatic model_reset();
    mq.delete();
    m_last_pc = 32'd0;
    m_stall   = 0;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] epc;
    epc = (mq.size() > 0) ? mq[0].pc : m_last_pc;
    chk({tag, ".valid"}, {31'd0, dn.valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    chk({tag, ".ready"}, {31'd0, up.ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
    chk({tag, ".pc"}, dn.pc, epc);
    chk({tag, ".pc4"}, o_pc_plus4, epc + 32'd4);
    chk({tag, ".instr"}, dn.instr, (mq.size() > 0) ? mq[0].instr : NOP);
    chk({tag, ".stall"}, {16'd0, o_stall_cnt}, m_stall);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input bit do_chk);
    bit acc, con;
    up.valid = v; up.pc = pc; up.instr = ins; dn.ready = rdy; i_flush = fl;
    acc = v && (mq.size() < 2);
    con = (mq.size() > 0) && rdy;
    if ((mq.size() > 0) && !rdy && m_stall < 65535) m_stall++;
    @(posedge i_clk);
    if (fl) mq.delete();
    else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc, instr: ins});
    end
    if (mq.size() > 0) m_last_pc = mq[0].pc;
    #1;
    if (do_chk) chk_model("rnd");
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_ready;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vt[$];

  task automatic async_reset_pulse();
    @(posedge i_clk);
    #3 i_reset_n = 1'b0;
    #1;
    chk("rst.valid", {31'd0, dn.valid}, 32'd0);
    chk("rst.ready", {31'd0, up.ready}, 32'd1);
    chk("rst.pc", dn.pc, 32'd0);
    chk("rst.pc4", o_pc_plus4, 32'd4);
    chk("rst.instr", dn.instr, NOP);
    chk("rst.stall", {16'd0, o_stall_cnt}, 32'd0);
    #2 i_reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    i_reset_n = 1'b0;
    up.valid = 1'b0; up.pc = '0; up.instr = '0; dn.ready = 1'b0; i_flush = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk_model("init");
    i_reset_n = 1'b1;

    // streaming, backpressure to FULL, flush in FULL, pc wrap
    vt.push_back('{1, 32'h00, 32'hA000_0000, 1, 0, 1, 32'h00, 32'hA000_0000, 1, 0});
    vt.push_back('{1, 32'h04, 32'hA000_0001, 1, 0, 1, 32'h04, 32'hA000_0001, 1, 0});
    vt.push_back('{1, 32'h08, 32'hA000_0002, 1, 0, 1, 32'h08, 32'hA000_0002, 1, 0});
    vt.push_back('{0, 32'h00, 32'h0,         1, 0, 0, 32'h08, NOP,           1, 0});
    vt.push_back('{1, 32'h10, 32'hB000_0000, 0, 0, 1, 32'h10, 32'hB000_0000, 1, 0});
    vt.push_back('{1, 32'h14, 32'hB000_0001, 0, 0, 1, 32'h10, 32'hB000_0000, 0, 1});
    vt.push_back('{1, 32'h99, 32'hDEAD_BEEF, 0, 0, 1, 32'h10, 32'hB000_0000, 0, 2});
    vt.push_back('{0, 32'h00, 32'h0,         1, 0, 1, 32'h14, 32'hB000_0001, 1, 2});
    vt.push_back('{0, 32'h00, 32'h0,         1, 0, 0, 32'h14, NOP,           1, 2});
    vt.push_back('{1, 32'h10, 32'hC000_0000, 0, 0, 1, 32'h10, 32'hC000_0000, 1, 2});
    vt.push_back('{1, 32'h14, 32'hC000_0001, 0, 0, 1, 32'h10, 32'hC000_0000, 0, 3});
    vt.push_back('{1, 32'h18, 32'hC000_0002, 0, 1, 0, 32'h10, NOP,           1, 4});
    vt.push_back('{0, 32'h00, 32'h0,         1, 0, 0, 32'h10, NOP,           1, 4});
    vt.push_back('{1, 32'hFFFF_FFFC, 32'hE000_0000, 1, 0, 1, 32'hFFFF_FFFC, 32'hE000_0000, 1, 4});
    vt.push_back('{0, 32'h00, 32'h0,         1, 0, 0, 32'hFFFF_FFFC, NOP,    1, 4});

    for (int i = 0; i < vt.size(); i++) begin
      up.valid = vt[i].v; up.pc = vt[i].pc; up.instr = vt[i].ins;
      dn.ready = vt[i].rdy; i_flush = vt[i].fl;
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d.valid", i), {31'd0, dn.valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("vec%0d.pc", i), dn.pc, vt[i].e_pc);
      chk($sformatf("vec%0d.pc4", i), o_pc_plus4, vt[i].e_pc + 32'd4);
      chk($sformatf("vec%0d.instr", i), dn.instr, vt[i].e_ins);
      chk($sformatf("vec%0d.ready", i), {31'd0, up.ready}, {31'd0, vt[i].e_ready});
      chk($sformatf("vec%0d.stall", i), {16'd0, o_stall_cnt}, {16'd0, vt[i].e_stall});
    end

    // fill to FULL, then reset mid-cycle: nothing held may come out afterwards
    step(1, 32'h20, 32'hF000_0000, 0, 0, 0);
    step(1, 32'h24, 32'hF000_0001, 0, 0, 0);
    async_reset_pulse();
    step(0, 32'h0, 32'h0, 1, 0, 1);
    step(1, 32'h40, 32'h1234_5678, 0, 0, 1);
    chk("post_rst.pc", dn.pc, 32'h40);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, 1);

    // saturation: hold a valid instruction with decode stalled
    async_reset_pulse();
    step(1, 32'h80, 32'h0BAD_F00D, 0, 0, 1);
    for (int i = 0; i < 65540; i++) step(0, 32'h0, 32'h0, 0, 0, 0);
    chk_model("sat");
    chk("sat.const", {16'd0, o_stall_cnt}, 32'h0000_FFFF);
    step(0, 32'h0, 32'h0, 0, 1, 1);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("sat.after_flush", {16'd0, o_stall_cnt}, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
